// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking neural network layer engine.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_e;

    // Adds two sign-extended values and clamps the result to a vbits-wide signed range.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 vbits
    );
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (vbits - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (vbits - 1));
        if (sum > hi) begin
            return 32'(hi);
        end
        if (sum < lo) begin
            return 32'(lo);
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead output FIFO with a sticky overflow flag; a push into a full FIFO is
// dropped unless a pop frees a slot in the same cycle.
module event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             overflow_q;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop);
    assign data_o     = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            if (push_i && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_layer_engine.sv
// Event-driven integrate-and-fire layer: each input spike walks all neurons adding
// the axon's weights, and each tick walks all neurons to fire or leak them.
module snn_layer_engine
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = 16,
    parameter int N_INPUTS   = 16,
    parameter int W_BITS     = 8,
    parameter int V_BITS     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int THRESHOLD  = 64,
    parameter int LEAK       = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(N_INPUTS)-1:0]  in_addr,
    input  logic                         tick,
    input  logic                         wt_we,
    input  logic [$clog2(N_INPUTS)-1:0]  wt_axon,
    input  logic [$clog2(N_NEURONS)-1:0] wt_neuron,
    input  logic signed [W_BITS-1:0]     wt_data,
    input  logic                         out_ren,
    output logic [$clog2(N_NEURONS)-1:0] out_addr,
    output logic                         out_empty,
    output logic                         overflow,
    output logic                         busy,
    input  logic [$clog2(N_NEURONS)-1:0] dbg_addr,
    output logic signed [V_BITS-1:0]     dbg_pot
);
    localparam int AW = $clog2(N_INPUTS);
    localparam int NW = $clog2(N_NEURONS);

    state_e                    state_q;
    logic [NW-1:0]             n_q;
    logic [AW-1:0]             axon_q;
    logic                      tick_pending_q;
    logic signed [W_BITS-1:0]  wt_q [N_INPUTS][N_NEURONS];
    logic signed [V_BITS-1:0]  v_q [N_NEURONS];
    logic signed [V_BITS-1:0]  vn;
    logic signed [V_BITS-1:0]  v_d;
    logic                      tick_fire;
    logic                      spike;

    assign vn        = v_q[n_q];
    assign tick_fire = tick_pending_q || tick;
    assign spike     = (state_q == FIRE) && (vn >= THRESHOLD);
    assign in_ready  = (state_q == IDLE) && !tick_fire;
    assign busy      = (state_q != IDLE) || tick_pending_q;
    assign dbg_pot   = v_q[dbg_addr];

    // Next potential of the neuron currently addressed by the sweep counter.
    always_comb begin
        v_d = vn;
        if (state_q == ACCUM) begin
            v_d = V_BITS'(sat_add(32'(vn), 32'(wt_q[axon_q][n_q]), V_BITS));
        end else if (state_q == FIRE) begin
            if (spike) begin
                v_d = '0;
            end else if (vn > LEAK) begin
                v_d = vn - V_BITS'(LEAK);
            end else if (vn < -LEAK) begin
                v_d = vn + V_BITS'(LEAK);
            end else begin
                v_d = '0;
            end
        end
    end

    // A tick seen in the same IDLE cycle that starts FIRE is consumed, not left pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            n_q            <= '0;
            axon_q         <= '0;
            tick_pending_q <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            if (tick) begin
                tick_pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tick_fire) begin
                        state_q        <= FIRE;
                        n_q            <= '0;
                        tick_pending_q <= 1'b0;
                    end else if (in_valid) begin
                        state_q <= ACCUM;
                        n_q     <= '0;
                        axon_q  <= in_addr;
                    end
                end
                ACCUM, FIRE: begin
                    v_q[n_q] <= v_d;
                    n_q      <= n_q + NW'(1);
                    if (n_q == NW'(N_NEURONS - 1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                for (int j = 0; j < N_NEURONS; j++) begin
                    wt_q[i][j] <= '0;
                end
            end
        end else if (wt_we) begin
            wt_q[wt_axon][wt_neuron] <= wt_data;
        end
    end

    event_fifo #(
        .WIDTH (NW),
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .push_i     (spike),
        .data_i     (n_q),
        .pop_i      (out_ren),
        .data_o     (out_addr),
        .empty_o    (out_empty),
        .overflow_o (overflow)
    );

endmodule

// File: tb/tb_snn_layer_engine.sv
// Self-checking bench for snn_layer_engine: a transaction-level layer model plus
// directed scenarios and a randomized event/tick/pop/weight-write mix.
module tb_snn_layer_engine;

    localparam int NN  = 16;
    localparam int NI  = 16;
    localparam int WB  = 8;
    localparam int VB  = 12;
    localparam int FD  = 8;
    localparam int THR = 64;
    localparam int LK  = 1;
    localparam int AIW = $clog2(NI);
    localparam int NIW = $clog2(NN);
    localparam int VMAX = (1 << (VB - 1)) - 1;
    localparam int VMIN = -(1 << (VB - 1));

    localparam int OP_EVENT = 0;
    localparam int OP_TICK  = 1;
    localparam int OP_POP   = 2;
    localparam int OP_WRITE = 3;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [AIW-1:0]        in_addr = '0;
    logic                  tick = 1'b0;
    logic                  wt_we = 1'b0;
    logic [AIW-1:0]        wt_axon = '0;
    logic [NIW-1:0]        wt_neuron = '0;
    logic signed [WB-1:0]  wt_data = '0;
    logic                  out_ren = 1'b0;
    logic [NIW-1:0]        out_addr;
    logic                  out_empty;
    logic                  overflow;
    logic                  busy;
    logic [NIW-1:0]        dbg_addr = '0;
    logic signed [VB-1:0]  dbg_pot;

    int checks = 0;
    int errors = 0;
    bit quiet = 1'b0;

    int mW [NI][NN];
    int mV [NN];
    int mQ [$];
    bit mOvf;

    snn_layer_engine #(
        .N_NEURONS  (NN),
        .N_INPUTS   (NI),
        .W_BITS     (WB),
        .V_BITS     (VB),
        .FIFO_DEPTH (FD),
        .THRESHOLD  (THR),
        .LEAK       (LK)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .tick      (tick),
        .wt_we     (wt_we),
        .wt_axon   (wt_axon),
        .wt_neuron (wt_neuron),
        .wt_data   (wt_data),
        .out_ren   (out_ren),
        .out_addr  (out_addr),
        .out_empty (out_empty),
        .overflow  (overflow),
        .busy      (busy),
        .dbg_addr  (dbg_addr),
        .dbg_pot   (dbg_pot)
    );

    always #5 clock = ~clock;

    // Reference model: whole transactions applied at once from the layer's rules.
    function automatic int clampV(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < NN; n++) begin
                mW[i][n] = 0;
            end
        end
        for (int n = 0; n < NN; n++) begin
            mV[n] = 0;
        end
        mQ.delete();
        mOvf = 1'b0;
    endfunction

    function automatic void modelEvent(input int a);
        for (int n = 0; n < NN; n++) begin
            mV[n] = clampV(mV[n] + mW[a][n]);
        end
    endfunction

    function automatic void modelFire();
        for (int n = 0; n < NN; n++) begin
            if (mV[n] >= THR) begin
                if (mQ.size() < FD) mQ.push_back(n);
                else mOvf = 1'b1;
                mV[n] = 0;
            end else if (mV[n] > LK) begin
                mV[n] = mV[n] - LK;
            end else if (mV[n] < -LK) begin
                mV[n] = mV[n] + LK;
            end else begin
                mV[n] = 0;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int op, input int a, input int b, input int c);
        case (op)
            OP_EVENT: begin
                quiet = 1'b0;
                @(posedge clock); #1;
                in_valid = 1'b1;
                in_addr  = AIW'(a);
                @(posedge clock); #1;
                in_valid = 1'b0;
                modelEvent(a);
                waitCycles(NN);
                quiet = 1'b1;
            end
            OP_TICK: begin
                quiet = 1'b0;
                @(posedge clock); #1;
                tick = 1'b1;
                @(posedge clock); #1;
                tick = 1'b0;
                checkOutput("busy_in_fire", busy, 1);
                modelFire();
                waitCycles(NN);
                quiet = 1'b1;
            end
            OP_POP: begin
                @(posedge clock); #1;
                out_ren = 1'b1;
                @(posedge clock); #1;
                out_ren = 1'b0;
                if (mQ.size() > 0) void'(mQ.pop_front());
            end
            default: begin
                @(posedge clock); #1;
                wt_we     = 1'b1;
                wt_axon   = AIW'(a);
                wt_neuron = NIW'(b);
                wt_data   = WB'(c);
                @(posedge clock); #1;
                wt_we = 1'b0;
                mW[a][b] = c;
            end
        endcase
    endtask

    task automatic applyReset();
        quiet = 1'b0;
        @(posedge clock); #3;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        tick     = 1'b0;
        out_ren  = 1'b0;
        wt_we    = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_out_empty", out_empty, 1);
        checkOutput("rst_out_addr", out_addr, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pot", dbg_pot, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        quiet = 1'b1;
    endtask

    task automatic checkPot(input int n, input int expected);
        @(posedge clock); #1;
        dbg_addr = NIW'(n);
        #1;
        checkOutput($sformatf("pot[%0d]", n), dbg_pot, expected);
    endtask

    task automatic scanAll();
        for (int n = 0; n < NN; n++) begin
            @(posedge clock); #1;
            dbg_addr = NIW'(n);
        end
        @(posedge clock); #1;
    endtask

    // Every settled cycle the visible outputs must match the model.
    initial begin
        forever begin
            @(negedge clock);
            if (quiet && reset_n) begin
                checkOutput("in_ready", in_ready, 1);
                checkOutput("busy", busy, 0);
                checkOutput("out_empty", out_empty, (mQ.size() == 0) ? 1 : 0);
                if (mQ.size() > 0) checkOutput("out_addr", out_addr, mQ[0]);
                checkOutput("overflow", overflow, mOvf);
                checkOutput("dbg_pot", dbg_pot, mV[dbg_addr]);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int r;
        modelReset();
        applyReset();

        // Two events through a single weight then one tick.
        applyStimulus(OP_WRITE, 2, 5, 40);
        applyStimulus(OP_EVENT, 2, 0, 0);
        applyStimulus(OP_EVENT, 2, 0, 0);
        checkPot(5, 80);
        checkOutput("model_v5_pre", mV[5], 80);
        applyStimulus(OP_TICK, 0, 0, 0);
        checkOutput("spike5_addr", out_addr, 5);
        checkOutput("spike5_empty", out_empty, 0);
        checkOutput("model_qsize", mQ.size(), 1);
        checkPot(5, 0);
        scanAll();
        applyStimulus(OP_POP, 0, 0, 0);
        checkOutput("empty_after_pop", out_empty, 1);
        applyStimulus(OP_POP, 0, 0, 0);

        // Positive saturation.
        applyReset();
        applyStimulus(OP_WRITE, 0, 0, 127);
        for (int i = 0; i < 20; i++) applyStimulus(OP_EVENT, 0, 0, 0);
        checkPot(0, 2047);
        checkOutput("model_sat", mV[0], 2047);
        applyStimulus(OP_TICK, 0, 0, 0);
        checkOutput("spike0_addr", out_addr, 0);
        checkOutput("spike0_empty", out_empty, 0);
        checkPot(0, 0);
        applyStimulus(OP_POP, 0, 0, 0);

        // Leak below threshold, and clamp to zero for small magnitudes.
        applyReset();
        applyStimulus(OP_WRITE, 1, 3, 10);
        applyStimulus(OP_EVENT, 1, 0, 0);
        applyStimulus(OP_TICK, 0, 0, 0);
        checkPot(3, 9);
        checkOutput("leak_no_spike", out_empty, 1);
        applyStimulus(OP_WRITE, 1, 4, -1);
        applyStimulus(OP_EVENT, 1, 0, 0);
        applyStimulus(OP_TICK, 0, 0, 0);
        checkPot(4, 0);
        checkPot(3, 18);
        checkOutput("model_v3", mV[3], 18);

        // Every neuron fires: the FIFO keeps the first eight and flags overflow.
        applyReset();
        for (int n = 0; n < NN; n++) applyStimulus(OP_WRITE, 0, n, 64);
        applyStimulus(OP_EVENT, 0, 0, 0);
        applyStimulus(OP_TICK, 0, 0, 0);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("model_qfull", mQ.size(), FD);
        scanAll();
        for (int i = 0; i < FD; i++) begin
            checkOutput($sformatf("fifo_order%0d", i), out_addr, i);
            applyStimulus(OP_POP, 0, 0, 0);
        end
        checkOutput("fifo_drained", out_empty, 1);
        checkOutput("ovf_sticky", overflow, 1);

        // Tick and event together: the tick sweep runs first.
        applyReset();
        applyStimulus(OP_WRITE, 3, 1, 5);
        quiet = 1'b0;
        @(posedge clock); #1;
        tick     = 1'b1;
        in_valid = 1'b1;
        in_addr  = AIW'(3);
        #1;
        checkOutput("ready_with_tick", in_ready, 0);
        @(posedge clock); #1;
        tick = 1'b0;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(posedge clock); #1;
            cnt++;
        end
        checkOutput("fire_latency", cnt, 16);
        @(posedge clock); #1;
        in_valid = 1'b0;
        modelFire();
        modelEvent(3);
        waitCycles(NN);
        quiet = 1'b1;
        checkPot(1, 5);

        // Reset in the middle of an accumulate sweep.
        applyReset();
        for (int n = 0; n < NN; n++) applyStimulus(OP_WRITE, 6, n, 20);
        quiet = 1'b0;
        dbg_addr = '0;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_addr  = AIW'(6);
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        checkOutput("accum_partial", dbg_pot, 20);
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("midrst_pot", dbg_pot, 0);
        checkOutput("midrst_empty", out_empty, 1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        checkOutput("midrst_ready", in_ready, 1);
        quiet = 1'b1;
        scanAll();
        checkPot(3, 0);

        // Randomized mix of weight writes, events, ticks and pops.
        applyReset();
        for (int k = 0; k < 250; k++) begin
            r = int'($urandom_range(0, 99));
            dbg_addr = NIW'($urandom_range(0, NN - 1));
            if (r < 35) begin
                applyStimulus(OP_WRITE, int'($urandom_range(0, 3)), int'($urandom_range(0, NN - 1)),
                              int'($urandom_range(0, 255)) - 128);
            end else if (r < 65) begin
                applyStimulus(OP_EVENT, int'($urandom_range(0, 3)), 0, 0);
            end else if (r < 80) begin
                applyStimulus(OP_TICK, 0, 0, 0);
            end else begin
                applyStimulus(OP_POP, 0, 0, 0);
            end
        end
        scanAll();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
